// File: rtl/cpm_acc_ctrl.sv
// CPM accumulation sequencer: clears, gates and drains the CPM
// MAC/register datapath per window and hands each result downstream.
module cpm_acc_ctrl #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned PIPE_LAT = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             CfgVld,
  output logic             CfgRdy,
  input  logic [CNT_W-1:0] CfgLen,
  input  logic [CNT_W-1:0] CfgRep,
  input  logic             Abort,
  input  logic             InVld,
  output logic             InRdy,
  output logic             AccEn,
  output logic             AccClear,
  output logic             OutVld,
  input  logic             OutRdy,
  output logic             OutLast,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ACC,
    S_DRAIN,
    S_OUT
  } state_e;

  localparam logic [3:0] LAT_INIT = 4'(PIPE_LAT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] rep_q;
  logic [CNT_W-1:0] op_q;
  logic [CNT_W-1:0] win_q;
  logic [3:0]       lat_q;
  logic             done_q;
  logic             abort_d;
  logic             last_d;

  assign last_d  = (win_q == rep_q);
  assign abort_d = Abort & Busy;

  assign CfgRdy  = (state_q == S_IDLE);
  assign Busy    = (state_q != S_IDLE);
  assign InRdy   = (state_q == S_ACC);
  assign OutVld  = (state_q == S_OUT);
  assign OutLast = OutVld & last_d;
  assign AccEn   = InVld & InRdy & ~Abort;
  assign Done    = done_q;

  // Abort wipes the partial sum at once; reset must not pulse a clear.
  assign AccClear = (state_q == S_CLR) | (abort_d & ~Rst);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      rep_q   <= '0;
      op_q    <= '0;
      win_q   <= '0;
      lat_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_d) begin
        state_q <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (CfgVld) begin
              len_q   <= CfgLen;
              rep_q   <= CfgRep;
              win_q   <= '0;
              state_q <= S_CLR;
            end
          end
          S_CLR: begin
            op_q    <= '0;
            state_q <= S_ACC;
          end
          S_ACC: begin
            if (AccEn) begin
              // Terminal compare first so all-ones length never wraps.
              if (op_q == len_q) begin
                lat_q   <= LAT_INIT;
                state_q <= S_DRAIN;
              end else begin
                op_q <= op_q + 1'b1;
              end
            end
          end
          S_DRAIN: begin
            if (lat_q == '0) begin
              state_q <= S_OUT;
            end else begin
              lat_q <= lat_q - 1'b1;
            end
          end
          S_OUT: begin
            if (OutRdy) begin
              if (last_d) begin
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                win_q   <= win_q + 1'b1;
                state_q <= S_CLR;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
